// File: rtl/control_unit.sv
// Multi-cycle processor sequencer: FETCH/DECODE/EXEC with memory-read and memory-write detours and a terminal HALT.
// Outputs are a combinational decode of state and opcode; memory requests hold until mem_ack, with no timeout.
module control_unit #(
  parameter logic [2:0] AC_SEL  = 3'd7,
  parameter logic [2:0] MDR_SEL = 3'd6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        Z_in,
  input  logic        mem_ack,
  output logic [3:0]  ALU_control,
  output logic [2:0]  bus_sel,
  output logic        reg_load_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMRD  = 3'd3,
    S_MEMWR  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_opcode;

  assign w_opcode = instruction[15:12];

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    ALU_control = 4'b0000;
    bus_sel     = 3'd0;
    reg_load_en = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    // Outputs are forced quiet while reset is held, whatever the state register holds.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: begin
          case (w_opcode)
            4'hB:    w_next = S_MEMRD;
            4'hC:    w_next = S_MEMWR;
            4'hF:    w_next = S_HALT;
            default: w_next = S_EXEC;
          endcase
        end
        S_EXEC: begin
          w_next = S_FETCH;
          case (w_opcode)
            4'h0, 4'h6, 4'h7, 4'h8, 4'h9: ALU_control = w_opcode;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
              ALU_control = w_opcode;
              bus_sel     = instruction[2:0];
            end
            4'hA: begin
              bus_sel     = AC_SEL;
              reg_load_en = 1'b1;
            end
            // Only reachable through MEMRD: move the fetched operand into AC.
            4'hB: begin
              bus_sel     = MDR_SEL;
              ALU_control = 4'b0101;
            end
            4'hD:    pc_load = 1'b1;
            4'hE:    pc_load = Z_in;
            default: ;
          endcase
        end
        S_MEMRD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ack) begin
            reg_load_en = 1'b1;
            w_next      = S_EXEC;
          end
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          bus_sel  = AC_SEL;
          if (mem_ack) w_next = S_FETCH;
        end
        S_HALT:  halted = 1'b1;
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Cycle-by-cycle vector table for the sequencer, plus hand-written HALT and reset sequences.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        Z_in;
  logic        mem_ack;
  logic [3:0]  ALU_control;
  logic [2:0]  bus_sel;
  logic        reg_load_en, mem_req, mem_we, addr_sel;
  logic        ir_load, pc_inc, pc_load, halted;

  always #5 clock = ~clock;

  control_unit #(.AC_SEL(3'd7), .MDR_SEL(3'd6)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .Z_in(Z_in),
    .mem_ack(mem_ack), .ALU_control(ALU_control), .bus_sel(bus_sel),
    .reg_load_en(reg_load_en), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .halted(halted)
  );

  // flag byte order: {reg_load_en, mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, halted}
  localparam logic [7:0] F_NONE   = 8'b0000_0000;
  localparam logic [7:0] F_FETCH  = 8'b0100_0000;
  localparam logic [7:0] F_FACK   = 8'b0100_1100;
  localparam logic [7:0] F_MRD    = 8'b0101_0000;
  localparam logic [7:0] F_MRDACK = 8'b1101_0000;
  localparam logic [7:0] F_MWR    = 8'b0111_0000;
  localparam logic [7:0] F_PCL    = 8'b0000_0010;
  localparam logic [7:0] F_RLE    = 8'b1000_0000;
  localparam logic [7:0] F_HLT    = 8'b0000_0001;

  typedef struct {
    logic        rst;
    logic [15:0] ins;
    logic        z;
    logic        ack;
    logic [14:0] exp;
  } vec_t;

  vec_t        vq[$];
  int          errors = 0;
  int          checks = 0;
  int          coinc  = 0;
  logic [14:0] obs;

  assign obs = {ALU_control, bus_sel, reg_load_en, mem_req, mem_we, addr_sel,
                ir_load, pc_inc, pc_load, halted};

  always @(negedge clock) if (pc_inc && pc_load) coinc++;

  function automatic logic [14:0] o(input logic [3:0] a, input logic [2:0] b, input logic [7:0] f);
    return {a, b, f};
  endfunction

  task automatic add(input logic rst, input logic [15:0] ins, input logic z, input logic ack,
                     input logic [3:0] a, input logic [2:0] b, input logic [7:0] f);
    vec_t t;
    t.rst = rst; t.ins = ins; t.z = z; t.ack = ack; t.exp = o(a, b, f);
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; instruction = 16'h0000; Z_in = 1'b0; mem_ack = 1'b0;

    // reset, then ADD r3 with ack on third FETCH cycle
    add(1, 16'h1003, 0, 0, 4'h0, 3'd0, F_NONE);
    add(1, 16'h1003, 0, 1, 4'h0, 3'd0, F_NONE);
    add(0, 16'h1003, 0, 0, 4'h0, 3'd0, F_FETCH);
    add(0, 16'h1003, 0, 0, 4'h0, 3'd0, F_FETCH);
    add(0, 16'h1003, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'h1003, 0, 1, 4'h0, 3'd0, F_NONE);   // stray ack in DECODE
    add(0, 16'h1003, 0, 0, 4'h1, 3'd3, F_NONE);
    // JMPZ taken, then not taken
    add(0, 16'hE020, 1, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hE020, 1, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hE020, 1, 0, 4'h0, 3'd0, F_PCL);
    add(0, 16'hE020, 1, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hE020, 1, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hE020, 0, 0, 4'h0, 3'd0, F_NONE);
    // LOAD with ack two cycles late
    add(0, 16'hB040, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hB040, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hB040, 0, 0, 4'h0, 3'd0, F_MRD);
    add(0, 16'hB040, 0, 0, 4'h0, 3'd0, F_MRD);
    add(0, 16'hB040, 0, 1, 4'h0, 3'd0, F_MRDACK);
    add(0, 16'hB040, 0, 0, 4'h5, 3'd6, F_NONE);
    // STORE with zero-wait ack
    add(0, 16'hC010, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hC010, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hC010, 0, 1, 4'h0, 3'd7, F_MWR);
    // STAC, JMP, INC, SUB (with a FETCH wait)
    add(0, 16'hA005, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hA005, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hA005, 0, 0, 4'h0, 3'd7, F_RLE);
    add(0, 16'hD123, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hD123, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hD123, 0, 0, 4'h0, 3'd0, F_PCL);
    add(0, 16'h7002, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'h7002, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'h7002, 0, 0, 4'h7, 3'd0, F_NONE);
    add(0, 16'h2004, 0, 0, 4'h0, 3'd0, F_FETCH);
    add(0, 16'h2004, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'h2004, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'h2004, 0, 0, 4'h2, 3'd4, F_NONE);
    // HALT with stray acks, then reset out of it
    add(0, 16'hF000, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hF000, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hF000, 0, 1, 4'h0, 3'd0, F_HLT);
    add(0, 16'hF000, 0, 1, 4'h0, 3'd0, F_HLT);
    add(0, 16'hF000, 0, 0, 4'h0, 3'd0, F_HLT);
    add(1, 16'hF000, 0, 0, 4'h0, 3'd0, F_NONE);
    // reset in the middle of a MEMRD wait
    add(0, 16'hB040, 0, 0, 4'h0, 3'd0, F_FETCH);
    add(0, 16'hB040, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'hB040, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hB040, 0, 0, 4'h0, 3'd0, F_MRD);
    add(1, 16'hB040, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'hB040, 0, 0, 4'h0, 3'd0, F_FETCH);
    add(0, 16'hB040, 0, 1, 4'h0, 3'd0, F_FACK);
    add(0, 16'h9001, 0, 0, 4'h0, 3'd0, F_NONE);
    add(0, 16'h9001, 0, 0, 4'h9, 3'd0, F_NONE);

    step();
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; instruction = vq[i].ins; Z_in = vq[i].z; mem_ack = vq[i].ack;
      #3;
      check($sformatf("vec%0d", i), obs, vq[i].exp);
      step();
    end

    // HALT persists over many cycles of random acks
    reset = 1'b1; instruction = 16'hF000; mem_ack = 1'b0; Z_in = 1'b0;
    step();
    reset = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    begin
      int n;
      n = 0;
      while (!halted && n < 8) begin
        step();
        n++;
      end
    end
    check("halt_reach", {14'd0, halted}, 15'd1);
    for (int i = 0; i < 16; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      Z_in    = 1'($urandom_range(0, 1));
      #3;
      check($sformatf("halt_hold%0d", i), obs, o(4'h0, 3'd0, F_HLT));
      step();
    end
    reset = 1'b1; mem_ack = 1'b1;
    #3;
    check("halt_rst", obs, o(4'h0, 3'd0, F_NONE));
    step();
    reset = 1'b0; mem_ack = 1'b0;
    #3;
    check("halt_rst_fetch", obs, o(4'h0, 3'd0, F_FETCH));
    step();

    checks++;
    if (coinc != 0) begin
      errors++;
      $display("FAIL pc_exclusive got=%0d expected=0", coinc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: AC_SEL, default 3'd7, bus_sel code that drives AC onto the B bus.
REQ-002 Parameter: MDR_SEL, default 3'd6, bus_sel code that drives the memory data register onto the B bus.
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: instruction  input  16  current IR contents; opcode [15:12], register field [2:0].
REQ-006 Port: Z_in  input  1  ALU zero flag (AC==0).
REQ-007 Port: mem_ack  input  1  memory completion strobe, one cycle.
REQ-008 Port: ALU_control  output  4  ALU operation code, sampled by ALU on the same clock edge.
REQ-009 Port: bus_sel  output  3  B-bus source select.
REQ-010 Port: reg_load_en  output  1  write enable for register instruction[2:0], or for MDR in MEMRD.
REQ-011 Port: mem_req  output  1  memory request, held until mem_ack.
REQ-012 Port: mem_we  output  1  1 = write, 0 = read; valid only while mem_req=1.
REQ-013 Port: addr_sel  output  1  0 = PC drives the address, 1 = instruction[11:0].
REQ-014 Port: ir_load, pc_inc, pc_load  output  1 each  IR capture, PC+1, PC<=instruction[11:0].
REQ-015 Port: halted  output  1  high in HALT state.

Function
REQ-016 FSM states: FETCH, DECODE, EXEC, MEMRD, MEMWR, HALT; outputs are a combinational decode of the state and the opcode.
REQ-017 FETCH: mem_req=1, mem_we=0, addr_sel=0.
REQ-018 FETCH on mem_ack: ir_load=1 and pc_inc=1 in the ack cycle; next state DECODE.
REQ-019 FETCH without mem_ack: remain in FETCH, all other outputs 0.
REQ-020 DECODE: lasts exactly one cycle, all outputs 0.
REQ-021 DECODE next state: opcode B goes to MEMRD, opcode C goes to MEMWR, opcode F goes to HALT, all others go to EXEC.
REQ-022 EXEC: lasts exactly one cycle, then FETCH.
REQ-023 EXEC, opcodes 0-9: ALU_control = opcode (0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOV, 6 LDC, 7 INC, 8 DEC, 9 CLR).
REQ-024 EXEC, opcodes 1-5: bus_sel = instruction[2:0].
REQ-025 EXEC, opcode A (STAC): bus_sel=AC_SEL, reg_load_en=1, ALU_control=0000.
REQ-026 EXEC, opcode D (JMP): pc_load=1.
REQ-027 EXEC, opcode E (JMPZ): pc_load=Z_in, using Z_in as sampled in the EXEC cycle.
REQ-028 ALU_control SHALL be 0000 in every state other than EXEC, so AC is never modified outside EXEC.
REQ-029 MEMRD: mem_req=1, mem_we=0, addr_sel=1.
REQ-030 MEMRD on mem_ack: reg_load_en=1 loads MDR; next state EXEC.
REQ-031 EXEC after MEMRD (opcode B): bus_sel=MDR_SEL, ALU_control=0101 (AC<=MDR).
REQ-032 MEMWR: mem_req=1, mem_we=1, addr_sel=1, bus_sel=AC_SEL; on mem_ack, next state FETCH.
REQ-033 mem_req SHALL stay high without gaps until mem_ack; there is no timeout.
REQ-034 mem_ack outside FETCH/MEMRD/MEMWR: ignored.
REQ-035 mem_ack in the first cycle of a request: accepted, giving zero-wait-state completion.
REQ-036 HALT: all outputs 0 except halted=1; remains in HALT until reset.
REQ-037 pc_inc and pc_load SHALL never be asserted in the same cycle.

Reset
REQ-038 reset=1 at a clock edge: state=FETCH on the next cycle, regardless of current state, including mid-request; any pending memory transaction is abandoned.
REQ-039 While reset=1: all outputs 0, ALU_control=0000, halted=0.
REQ-040 First cycle after reset deasserts: mem_req=1 with addr_sel=0.

Verification
REQ-041 Reset release, mem_ack on 3rd FETCH cycle, instruction=16'h1003 -> ir_load/pc_inc pulse once; one DECODE cycle; EXEC ALU_control=0001, bus_sel=3; next cycle FETCH.
REQ-042 instruction=16'hE020, Z_in=1 then Z_in=0 -> pc_load=1 in EXEC only for Z_in=1; pc_inc never coincident.
REQ-043 instruction=16'hB040, mem_ack 2 cycles late -> MEMRD holds mem_req/addr_sel=1 without gaps; reg_load_en in ack cycle; EXEC ALU_control=0101, bus_sel=6.
REQ-044 instruction=16'hC010, immediate ack -> one MEMWR cycle, mem_we=1, bus_sel=7; ALU_control stays 0000 throughout.
REQ-045 instruction=16'hF000 -> halted=1 indefinitely with stray mem_ack ignored; reset mid-MEMRD and in HALT -> FETCH next cycle, outputs zeroed.
